// File: rtl/time_bcd_formatter_pkg.sv
// ============================================================================
// Module : time_disp_pkg
// Brief  : Shared constants and FSM state type for the time BCD formatter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package time_disp_pkg;

  localparam logic       MODE_TIMER  = 1'b0;
  localparam logic       MODE_CLOCK  = 1'b1;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam int         MAX_MIN_SEC = 59;
  localparam int         MAX_HOUR    = 23;

  localparam int         PASS_TIMER  = 1;
  localparam int         PASS_CLOCK  = 3;

  localparam int         BCD_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ============================================================================
// Module : bcd_dabble_step
// Brief  : One double-dabble iteration: add 3 to every nibble >= 5, then shift
//          the accumulator left by one bit with bit_in entering at the LSB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_step
  import time_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             bit_in,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BCD_W-1:0] w_corrected;

  for (genvar n = 0; n < BCD_W / 4; n++) begin : g_nibble
    always_comb begin
      if (bcd_in[n*4 +: 4] >= 4'd5) begin
        w_corrected[n*4 +: 4] = bcd_in[n*4 +: 4] + 4'd3;
      end else begin
        w_corrected[n*4 +: 4] = bcd_in[n*4 +: 4];
      end
    end
  end

  assign bcd_out = {w_corrected[BCD_W-2:0], bit_in};

endmodule

`default_nettype wire

// File: rtl/time_bcd_formatter.sv
// ============================================================================
// Module : time_bcd_formatter
// Brief  : Converts timer or hh:mm:ss values into six BCD display digits with
//          a single iterative double-dabble engine. Optional macro
//          LEADING_ZERO_BLANK_EN blanks leading zeros in timer mode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module time_bcd_formatter
  import time_disp_pkg::*;
#(
  parameter int VAL_W   = 10,
  parameter int FIELD_W = 6,
  parameter int HOUR_W  = 5
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [VAL_W-1:0]   value,
  input  logic [HOUR_W-1:0]  hour_in,
  input  logic [FIELD_W-1:0] min_in,
  input  logic [FIELD_W-1:0] sec_in,
  output logic               ready,
  output logic               done,
  output logic               ovr,
  output logic [3:0]         digit5,
  output logic [3:0]         digit4,
  output logic [3:0]         digit3,
  output logic [3:0]         digit2,
  output logic [3:0]         digit1,
  output logic [3:0]         digit0
);

  localparam int CNT_W = $clog2(VAL_W + 1);

  state_t             r_state;
  state_t             w_next_state;

  logic               r_mode;
  logic [VAL_W-1:0]   r_value;
  logic [HOUR_W-1:0]  r_hour;
  logic [FIELD_W-1:0] r_min;
  logic [FIELD_W-1:0] r_sec;

  logic [1:0]         r_pass;
  logic [CNT_W-1:0]   r_cnt;
  logic [VAL_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_next;
  logic [VAL_W-1:0]   w_operand;

  logic [23:0]        r_shadow;
  logic [23:0]        w_shadow_next;
  logic [23:0]        r_digits;
  logic [23:0]        w_disp;
  logic               r_ovr;
  logic               w_range_ovr;
  logic               w_last_shift;
  logic               w_last_pass;

`ifdef LEADING_ZERO_BLANK_EN
  logic               r_disp_mode;
`endif

  assign w_last_shift = (r_cnt == CNT_W'(VAL_W - 1));
  assign w_last_pass  = (r_mode == MODE_TIMER) || (r_pass == 2'(PASS_CLOCK - 1));

  assign w_range_ovr = (r_mode == MODE_CLOCK) &&
                       ((r_min  > FIELD_W'(MAX_MIN_SEC)) ||
                        (r_sec  > FIELD_W'(MAX_MIN_SEC)) ||
                        (r_hour > HOUR_W'(MAX_HOUR)));

  // Clock mode walks sec -> min -> hour, one operand per pass.
  always_comb begin
    w_operand = r_value;
    if (r_mode == MODE_CLOCK) begin
      case (r_pass)
        2'd0:    w_operand = VAL_W'(r_sec);
        2'd1:    w_operand = VAL_W'(r_min);
        default: w_operand = VAL_W'(r_hour);
      endcase
    end
  end

  always_comb begin
    w_shadow_next = r_shadow;
    if (r_mode == MODE_TIMER) begin
      w_shadow_next = {8'h00, r_bcd};
    end else begin
      case (r_pass)
        2'd0:    w_shadow_next[7:0]   = r_bcd[7:0];
        2'd1:    w_shadow_next[15:8]  = r_bcd[7:0];
        default: w_shadow_next[23:16] = r_bcd[7:0];
      endcase
    end
  end

  bcd_dabble_step u_step (
    .bcd_in  (r_bcd),
    .bit_in  (r_shift[VAL_W-1]),
    .bcd_out (w_bcd_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD:  w_next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last_shift) begin
          w_next_state = ST_STORE;
        end
      end
      ST_STORE: w_next_state = w_last_pass ? ST_DONE : ST_LOAD;
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_TIMER;
      r_value  <= '0;
      r_hour   <= '0;
      r_min    <= '0;
      r_sec    <= '0;
      r_pass   <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_shadow <= '0;
      r_digits <= '0;
      r_ovr    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_disp_mode <= MODE_CLOCK;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_value <= value;
            r_hour  <= hour_in;
            r_min   <= min_in;
            r_sec   <= sec_in;
            r_pass  <= '0;
          end
        end
        ST_LOAD: begin
          r_bcd   <= '0;
          r_shift <= w_operand;
          r_cnt   <= '0;
        end
        ST_SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= {r_shift[VAL_W-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
        end
        ST_STORE: begin
          r_shadow <= w_shadow_next;
          r_pass   <= r_pass + 2'd1;
          // Publish on the edge into DONE so digits, ovr and done move together.
          if (w_last_pass) begin
            r_digits <= w_shadow_next;
            r_ovr    <= w_range_ovr;
`ifdef LEADING_ZERO_BLANK_EN
            r_disp_mode <= r_mode;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_disp = r_digits;
    if (r_disp_mode == MODE_TIMER) begin
      w_disp[23:20] = BLANK_DIGIT;
      w_disp[19:16] = BLANK_DIGIT;
      if (r_digits[15:12] == 4'd0) begin
        w_disp[15:12] = BLANK_DIGIT;
        if (r_digits[11:8] == 4'd0) begin
          w_disp[11:8] = BLANK_DIGIT;
          if (r_digits[7:4] == 4'd0) begin
            w_disp[7:4] = BLANK_DIGIT;
          end
        end
      end
    end
  end
`else
  assign w_disp = r_digits;
`endif

  assign ovr    = r_ovr;
  assign digit5 = w_disp[23:20];
  assign digit4 = w_disp[19:16];
  assign digit3 = w_disp[15:12];
  assign digit2 = w_disp[11:8];
  assign digit1 = w_disp[7:4];
  assign digit0 = w_disp[3:0];

endmodule

`default_nettype wire

// File: tb/tb_time_bcd_formatter.sv
// ============================================================================
// Module : tb_time_bcd_formatter
// Brief  : Self-checking bench with a cycle-level reference model plus
//          directed literal expectations for the time BCD formatter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_time_bcd_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] value = '0;
  logic [4:0] hour_in = '0;
  logic [5:0] min_in = '0;
  logic [5:0] sec_in = '0;
  logic       ready, done, ovr;
  logic [3:0] digit5, digit4, digit3, digit2, digit1, digit0;
  logic [23:0] disp;

  int vectors = 0;
  int miscompares = 0;

  time_bcd_formatter dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .value   (value),
    .hour_in (hour_in),
    .min_in  (min_in),
    .sec_in  (sec_in),
    .ready   (ready),
    .done    (done),
    .ovr     (ovr),
    .digit5  (digit5),
    .digit4  (digit4),
    .digit3  (digit3),
    .digit2  (digit2),
    .digit1  (digit1),
    .digit0  (digit0)
  );

  assign disp = {digit5, digit4, digit3, digit2, digit1, digit0};

  always #5 clk = ~clk;

  // Expected display for one conversion, straight from decimal arithmetic.
  function automatic logic [23:0] fmt(input bit md, input int v, input int h,
                                      input int mi, input int s);
    int d[6];
    logic [23:0] r;
    if (!md) begin
      d[5] = 0; d[4] = 0;
      d[3] = (v / 1000) % 10; d[2] = (v / 100) % 10;
      d[1] = (v / 10) % 10;   d[0] = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
      d[5] = 15; d[4] = 15;
      for (int i = 3; i >= 1; i--) begin
        if (d[i] != 0) break;
        d[i] = 15;
      end
`endif
    end else begin
      d[5] = h / 10;  d[4] = h % 10;
      d[3] = mi / 10; d[2] = mi % 10;
      d[1] = s / 10;  d[0] = s % 10;
    end
    r = '0;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(d[i]);
    return r;
  endfunction

  // Reference model: remaining latency counter and published display.
  int          m_rem = 0;
  bit          m_done = 0;
  logic [23:0] m_disp = '0;
  bit          m_ovr = 0;
  logic [23:0] m_pend = '0;
  bit          m_pend_ovr = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = 0; m_done = 0; m_disp = '0; m_ovr = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_done = 1; m_disp = m_pend; m_ovr = m_pend_ovr;
      end
    end else if (start) begin
      m_rem      = mode ? 36 : 12;
      m_pend     = fmt(mode, int'(value), int'(hour_in), int'(min_in), int'(sec_in));
      m_pend_ovr = mode && (min_in > 59 || sec_in > 59 || hour_in > 23);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      vectors++;
      if (ready !== (!m_done && m_rem == 0) || done !== m_done ||
          ovr !== m_ovr || disp !== m_disp) begin
        miscompares++;
        $display("FAIL model t=%0t ready=%b done=%b ovr=%b disp=%h required ready=%b done=%b ovr=%b disp=%h",
                 $time, ready, done, ovr, disp, (!m_done && m_rem == 0), m_done, m_ovr, m_disp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; return the cycle in which done appears (-1 on timeout).
  task automatic run(input bit md, input int v, input int h, input int mi,
                     input int s, output int lat);
    int k;
    @(negedge clk);
    mode = md; value = 10'(v); hour_in = 5'(h); min_in = 6'(mi); sec_in = 6'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    lat = done ? k : -1;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [23:0] E1023 = 24'hFF1023;
  localparam logic [23:0] E250  = 24'hFFF250;
  localparam logic [23:0] E7    = 24'hFFFFF7;
  localparam logic [23:0] E0    = 24'hFFFFF0;
  localparam logic [23:0] E1005 = 24'hFF1005;
`else
  localparam logic [23:0] E1023 = 24'h001023;
  localparam logic [23:0] E250  = 24'h000250;
  localparam logic [23:0] E7    = 24'h000007;
  localparam logic [23:0] E0    = 24'h000000;
  localparam logic [23:0] E1005 = 24'h001005;
`endif

  initial begin
    int lat;
    int ndone;
    bit bad;
    repeat (3) @(negedge clk);
    chk("reset_digits", {8'h0, disp}, 32'h0);
    chk("reset_ready", {31'h0, ready}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    run(1'b0, 1023, 0, 0, 0, lat);
    chk("timer_latency", lat, 13);
    chk("timer_1023", {8'h0, disp}, {8'h0, E1023});
    chk("timer_ovr", {31'h0, ovr}, 32'h0);
    @(negedge clk);
    chk("ready_after_done", {31'h0, ready}, 32'h1);

    run(1'b1, 0, 23, 59, 58, lat);
    chk("clock_latency", lat, 37);
    chk("clock_235958", {8'h0, disp}, 32'h235958);
    chk("clock_ovr0", {31'h0, ovr}, 32'h0);

    run(1'b1, 0, 12, 60, 5, lat);
    chk("clock_126005", {8'h0, disp}, 32'h126005);
    chk("clock_ovr_min", {31'h0, ovr}, 32'h1);
    run(1'b1, 0, 24, 0, 0, lat);
    chk("clock_240000", {8'h0, disp}, 32'h240000);
    chk("clock_ovr_hour", {31'h0, ovr}, 32'h1);

    // Start pulses during a running conversion must be ignored.
    @(negedge clk);
    mode = 1'b0; value = 10'd250; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3 || k == 12) begin
        start = 1'b1; value = 10'd999;
      end
      if (done) ndone++;
    end
    start = 1'b0;
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_digits", {8'h0, disp}, {8'h0, E250});

    // Reset mid-conversion: no done, outputs cleared.
    @(negedge clk);
    mode = 1'b1; hour_in = 5'd1; min_in = 6'd2; sec_in = 6'd3; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (k == 20);
      if (done) ndone++;
    end
    reset = 1'b0;
    chk("abort_no_done", ndone, 0);
    chk("abort_digits", {8'h0, disp}, 32'h0);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    run(1'b1, 0, 1, 2, 3, lat);
    chk("restart_latency", lat, 37);
    chk("restart_010203", {8'h0, disp}, 32'h010203);

    run(1'b0, 7, 0, 0, 0, lat);
    chk("timer_7", {8'h0, disp}, {8'h0, E7});
    run(1'b0, 0, 0, 0, 0, lat);
    chk("timer_0", {8'h0, disp}, {8'h0, E0});
    run(1'b0, 1005, 0, 0, 0, lat);
    chk("timer_1005", {8'h0, disp}, {8'h0, E1005});

    // Pin the model against independent literals.
    bad = (fmt(1'b1, 0, 23, 59, 58) !== 24'h235958) || (fmt(1'b0, 1023, 0, 0, 0) !== E1023);
    chk("model_pin", {31'h0, bad}, 32'h0);

    // Digits hold across an idle stretch.
    repeat (20) @(negedge clk);
    chk("idle_hold", {8'h0, disp}, {8'h0, E1005});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
